// File: rtl/pipe3_skid.sv
// Execute-to-memory/writeback pipeline register with a valid/ready handshake and a
// one-entry skid buffer. Define PIPE3_FWD_EN to add the ALU-result forwarding outputs.
module pipe3_skid #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned MADDR_W = 21,
    parameter int unsigned BEN_W   = 16,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [0:DATA_W-1]  alures_in,
    input  logic [0:DATA_W-1]  stdata_in,
    input  logic               memWrEn_in,
    input  logic               memEn_in,
    input  logic [0:MADDR_W-1] memAddr_in,
    input  logic [0:BEN_W-1]   wbyteen_in,
    input  logic               regwren_in,
    input  logic [0:RADDR_W-1] rwraddrd_in,
    input  logic               reginmuxop_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:DATA_W-1]  alures_out,
    output logic [0:DATA_W-1]  stdata_out,
    output logic               memWrEn_out,
    output logic               memEn_out,
    output logic [0:MADDR_W-1] memAddr_out,
    output logic [0:BEN_W-1]   wbyteen_out,
    output logic               regwren_out,
    output logic [0:RADDR_W-1] rwraddrd_out,
    output logic               reginmuxop_out
`ifdef PIPE3_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [0:RADDR_W-1] fwd_addr,
    output logic [0:DATA_W-1]  fwd_data
`endif
);

    typedef struct packed {
        logic [0:DATA_W-1]  alures;
        logic [0:DATA_W-1]  stdata;
        logic               memwren;
        logic               memen;
        logic [0:MADDR_W-1] memaddr;
        logic [0:BEN_W-1]   wbyteen;
        logic               regwren;
        logic [0:RADDR_W-1] rwraddrd;
        logic               reginmuxop;
    } entry_t;

    entry_t in_ent;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept, drain;

    always_comb begin
        in_ent.alures     = alures_in;
        in_ent.stdata     = stdata_in;
        in_ent.memwren    = memWrEn_in;
        in_ent.memen      = memEn_in;
        in_ent.memaddr    = memAddr_in;
        in_ent.wbyteen    = wbyteen_in;
        in_ent.regwren    = regwren_in;
        in_ent.rwraddrd   = rwraddrd_in;
        in_ent.reginmuxop = reginmuxop_in;
    end

    // in_ready comes straight from a flop, so it never sees out_ready combinationally.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no new input competes with the skid entry.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_ent;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_ent;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid      = main_valid_q;
    assign alures_out     = main_q.alures;
    assign stdata_out     = main_q.stdata;
    assign memAddr_out    = main_q.memaddr;
    assign wbyteen_out    = main_q.wbyteen;
    assign rwraddrd_out   = main_q.rwraddrd;
    assign reginmuxop_out = main_q.reginmuxop;
    // Side-effect strobes are gated so a stale entry can never write memory or registers.
    assign memWrEn_out    = main_valid_q & main_q.memwren;
    assign memEn_out      = main_valid_q & main_q.memen;
    assign regwren_out    = main_valid_q & main_q.regwren;

`ifdef PIPE3_FWD_EN
    assign fwd_valid = main_valid_q & main_q.regwren & ~main_q.reginmuxop;
    assign fwd_addr  = main_q.rwraddrd;
    assign fwd_data  = main_q.alures;
`endif

endmodule

// File: tb/tb_pipe3_skid.sv
// Randomised self-checking bench for pipe3_skid against a two-deep FIFO queue model.
module tb_pipe3_skid;

    typedef struct packed {
        logic [0:127] alu;
        logic [0:127] st;
        logic         mwe;
        logic         men;
        logic [0:20]  addr;
        logic [0:15]  ben;
        logic         rwe;
        logic [0:4]   rd;
        logic         mux;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;
    ent_t cur = '0;

    logic         in_ready, out_valid;
    logic [0:127] alures_out, stdata_out;
    logic         memWrEn_out, memEn_out, regwren_out, reginmuxop_out;
    logic [0:20]  memAddr_out;
    logic [0:15]  wbyteen_out;
    logic [0:4]   rwraddrd_out;
    ent_t         obs;
`ifdef PIPE3_FWD_EN
    logic         fwd_valid;
    logic [0:4]   fwd_addr;
    logic [0:127] fwd_data;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    pipe3_skid dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .alures_in     (cur.alu),
        .stdata_in     (cur.st),
        .memWrEn_in    (cur.mwe),
        .memEn_in      (cur.men),
        .memAddr_in    (cur.addr),
        .wbyteen_in    (cur.ben),
        .regwren_in    (cur.rwe),
        .rwraddrd_in   (cur.rd),
        .reginmuxop_in (cur.mux),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alures_out    (alures_out),
        .stdata_out    (stdata_out),
        .memWrEn_out   (memWrEn_out),
        .memEn_out     (memEn_out),
        .memAddr_out   (memAddr_out),
        .wbyteen_out   (wbyteen_out),
        .regwren_out   (regwren_out),
        .rwraddrd_out  (rwraddrd_out),
        .reginmuxop_out(reginmuxop_out)
`ifdef PIPE3_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data)
`endif
    );

    assign obs = {alures_out, stdata_out, memWrEn_out, memEn_out, memAddr_out, wbyteen_out,
                  regwren_out, rwraddrd_out, reginmuxop_out};

    function automatic ent_t rand_ent();
        logic [319:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom};
        return ent_t'(r[301:0]);
    endfunction

    // Model: a FIFO of at most two entries; ready while fewer than two are held.
    task automatic tick();
        bit   acc, drn, f;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        f   = flush;
        e   = cur;
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (drn) q.delete(0);
            if (acc) q.push_back(e);
        end
    endtask

    task automatic clear_pipe();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_vec++;
        if (obs !== '0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0", obs);
        end
`ifdef PIPE3_FWD_EN
        n_vec++;
        if (fwd_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_fwd_valid got %b want 0", fwd_valid);
        end
`endif
        reset = 1'b1;
        q.delete();
    endtask

    task automatic test_basic();
        clear_pipe();
        cur       = '0;
        cur.alu   = 128'h1;
        cur.rwe   = 1'b1;
        cur.rd    = 5'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        n_vec++;
        if ({out_valid, alures_out, regwren_out, rwraddrd_out} !== {1'b1, 128'h1, 1'b1, 5'd3}) begin
            n_err++;
            $display("FAIL basic_latency got v=%b alu=%h rwe=%b rd=%0d want v=1 alu=1 rwe=1 rd=3",
                     out_valid, alures_out, regwren_out, rwraddrd_out);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_drained got %b want 0", out_valid);
        end
    endtask

    task automatic test_stall_order();
        int           k;
        bit           acc;
        logic [0:127] seen[$];
        clear_pipe();
        k         = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 40 && seen.size() < 4; c++) begin
            in_valid = (k < 4);
            cur      = rand_ent();
            cur.alu  = 128'(k + 1);
            if (c == 2) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++; $display("FAIL stall_skid_full in_ready got %b want 0", in_ready);
                end
                out_ready = 1'b1;
            end
            if (q.size() > 0) begin
                n_vec++;
                if (obs !== q[0]) begin
                    n_err++; $display("FAIL stall_front got %h want %h", obs, q[0]);
                end
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) seen.push_back(alures_out);
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (seen.size() != 4) begin
            n_err++; $display("FAIL stall_count got %0d want 4", seen.size());
        end
        for (int i = 0; i < seen.size(); i++) begin
            n_vec++;
            if (seen[i] !== 128'(i + 1)) begin
                n_err++; $display("FAIL stall_order[%0d] got %h want %0d", i, seen[i], i + 1);
            end
        end
    endtask

    task automatic test_hold_flush();
        ent_t e;
        clear_pipe();
        e         = rand_ent();
        e.mwe     = 1'b1;
        e.addr    = 21'h1F;
        cur       = e;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({out_valid, memWrEn_out, obs} !== {1'b1, 1'b1, e}) begin
                n_err++;
                $display("FAIL hold_stable[%0d] got v=%b we=%b %h want v=1 we=1 %h",
                         c, out_valid, memWrEn_out, obs, e);
            end
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if ({out_valid, memWrEn_out} !== 2'b00) begin
            n_err++; $display("FAIL hold_flush got v=%b we=%b want 0 0", out_valid, memWrEn_out);
        end
    endtask

    task automatic test_flush_full();
        clear_pipe();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur       = rand_ent();
        tick();
        cur       = rand_ent();
        tick();
        n_vec++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_err++; $display("FAIL full_state got v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        cur   = rand_ent();
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, memEn_out, regwren_out} !== 4'b0100) begin
            n_err++;
            $display("FAIL flush_full got v=%b rdy=%b men=%b rwe=%b want 0 1 0 0",
                     out_valid, in_ready, memEn_out, regwren_out);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_no_emit got %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        clear_pipe();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur       = rand_ent();
        cur.men   = 1'b1;
        cur.rwe   = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, memEn_out, regwren_out, in_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL async_reset got v=%b men=%b rwe=%b rdy=%b want 0 0 0 1",
                     out_valid, memEn_out, regwren_out, in_ready);
        end
        q.delete();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cur       = rand_ent();
            n_vec++;
            if ({out_valid, in_ready} !== {q.size() > 0, q.size() < 2}) begin
                n_err++;
                $display("FAIL rand_hs[%0d] got v=%b rdy=%b want %b %b", c, out_valid, in_ready,
                         q.size() > 0, q.size() < 2);
            end
            n_vec++;
            if (q.size() > 0) begin
                if (obs !== q[0]) begin
                    n_err++; $display("FAIL rand_data[%0d] got %h want %h", c, obs, q[0]);
                end
            end else if ({memWrEn_out, memEn_out, regwren_out} !== 3'b000) begin
                n_err++;
                $display("FAIL rand_gate[%0d] got %b%b%b want 000", c, memWrEn_out, memEn_out,
                         regwren_out);
            end
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

`ifdef PIPE3_FWD_EN
    task automatic test_fwd();
        clear_pipe();
        out_ready = 1'b0;
        cur       = '0;
        cur.alu   = 128'hAB;
        cur.rwe   = 1'b1;
        cur.rd    = 5'd7;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        n_vec++;
        if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 5'd7, 128'hAB}) begin
            n_err++;
            $display("FAIL fwd_alu got v=%b a=%0d d=%h want 1 7 ab", fwd_valid, fwd_addr, fwd_data);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (fwd_valid !== 1'b0) begin
            n_err++; $display("FAIL fwd_after_flush got %b want 0", fwd_valid);
        end
        cur.mux  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, fwd_valid} !== 2'b10) begin
            n_err++; $display("FAIL fwd_memsel got v=%b fwd=%b want 1 0", out_valid, fwd_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall_order();
        test_hold_flush();
        test_flush_full();
        test_async_reset();
        test_random();
`ifdef PIPE3_FWD_EN
        test_fwd();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
